svc_axil_arbiter_rd: RTL and testbench



---
 rtl/svc_axil_arbiter_rd.sv | 215 +++++++++++++++++++++
 tb/tb_svc_axil_arbiter_rd.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/svc_axil_arbiter_rd.sv
// rtl/svc_axil_arbiter_rd.sv - round-robin arbiter sharing one AXI-lite read port among NUM_M managers
//
// Purpose: grants one upstream manager at a time (round-robin, one outstanding
// transaction), forwards its AR to the downstream port and steers the R
// response back only to the granted manager.
//
// Optional feature macro: SVC_AXIL_ARBITER_RD_TIMEOUT_EN
//   When defined, a response that does not arrive within TIMEOUT_CYCLES of
//   entering R is answered locally with DEADBEEF/SLVERR, and the late
//   downstream response is drained and discarded.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   s_axil_ar{valid,addr,ready} per-manager read address channels (flattened)
//   s_axil_r{valid,data,resp,ready} per-manager read data channels (flattened)
//   m_axil_ar{valid,addr,ready} downstream read address channel
//   m_axil_r{valid,data,resp,ready} downstream read data channel
module svc_axil_arbiter_rd #(
  parameter int AXIL_ADDR_WIDTH = 32,
  parameter int AXIL_DATA_WIDTH = 32,
  parameter int NUM_M           = 3,
  parameter int TIMEOUT_CYCLES  = 256
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NUM_M-1:0]                   s_axil_arvalid,
  input  logic [NUM_M*AXIL_ADDR_WIDTH-1:0]   s_axil_araddr,
  output logic [NUM_M-1:0]                   s_axil_arready,
  output logic [NUM_M-1:0]                   s_axil_rvalid,
  output logic [NUM_M*AXIL_DATA_WIDTH-1:0]   s_axil_rdata,
  output logic [NUM_M*2-1:0]                 s_axil_rresp,
  input  logic [NUM_M-1:0]                   s_axil_rready,
  output logic                               m_axil_arvalid,
  output logic [AXIL_ADDR_WIDTH-1:0]         m_axil_araddr,
  input  logic                               m_axil_arready,
  input  logic                               m_axil_rvalid,
  input  logic [AXIL_DATA_WIDTH-1:0]         m_axil_rdata,
  input  logic [1:0]                         m_axil_rresp,
  output logic                               m_axil_rready
);

  localparam int AW = AXIL_ADDR_WIDTH;
  localparam int DW = AXIL_DATA_WIDTH;
  localparam int IW = (NUM_M > 1) ? $clog2(NUM_M) : 1;

`ifdef SVC_AXIL_ARBITER_RD_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [DW-1:0] TO_DATA = DW'(32'hDEAD_BEEF);
  typedef enum logic [2:0] {IDLE, AR, R, TMO, DRAIN} state_t;
`else
  typedef enum logic [1:0] {IDLE, AR, R} state_t;
`endif

  state_t          state_q, state_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]   gnt_q, gnt_d;
  logic [AW-1:0]   araddr_q, araddr_d;
  logic            active_q, active_d;
`ifdef SVC_AXIL_ARBITER_RD_TIMEOUT_EN
  logic [CW-1:0]   cnt_q, cnt_d;
`endif

  // Round-robin search: first requester at or after rr_ptr, wrapping at NUM_M.
  logic            arb_found;
  logic [IW-1:0]   arb_idx;
  logic [AW-1:0]   arb_addr;
  int              cand;

  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    arb_addr  = '0;
    cand      = 0;
    for (int i = 0; i < NUM_M; i++) begin
      cand = int'(rr_ptr_q) + i;
      if (cand >= NUM_M) cand = cand - NUM_M;
      if (!arb_found && s_axil_arvalid[IW'(cand)]) begin
        arb_found = 1'b1;
        arb_idx   = IW'(cand);
      end
    end
    for (int k = 0; k < NUM_M; k++) begin
      if (IW'(k) == arb_idx) arb_addr = s_axil_araddr[k*AW +: AW];
    end
  end

  // Granted manager's R ready, and the pointer value after it is served.
  logic          gnt_rready;
  logic [IW-1:0] next_ptr;

  always_comb begin
    gnt_rready = 1'b0;
    for (int k = 0; k < NUM_M; k++) begin
      if (IW'(k) == gnt_q) gnt_rready = s_axil_rready[k];
    end
    next_ptr = (gnt_q == IW'(NUM_M - 1)) ? '0 : gnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      gnt_q    <= '0;
      araddr_q <= '0;
      active_q <= 1'b0;
`ifdef SVC_AXIL_ARBITER_RD_TIMEOUT_EN
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gnt_q    <= gnt_d;
      araddr_q <= araddr_d;
      active_q <= active_d;
`ifdef SVC_AXIL_ARBITER_RD_TIMEOUT_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  always_comb begin
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    gnt_d          = gnt_q;
    araddr_d       = araddr_q;
    active_d       = active_q;
`ifdef SVC_AXIL_ARBITER_RD_TIMEOUT_EN
    cnt_d          = cnt_q;
`endif
    s_axil_arready = '0;
    s_axil_rvalid  = '0;
    s_axil_rdata   = '0;
    s_axil_rresp   = '0;
    m_axil_arvalid = (state_q == AR);
    m_axil_araddr  = araddr_q;
    m_axil_rready  = 1'b0;

    case (state_q)
      IDLE: begin
        // rst_n gates the grant so arready stays low while reset is held.
        if (arb_found && rst_n && !active_q) begin
          for (int k = 0; k < NUM_M; k++) begin
            if (IW'(k) == arb_idx) s_axil_arready[k] = 1'b1;
          end
          araddr_d = arb_addr;
          gnt_d    = arb_idx;
          active_d = 1'b1;
          state_d  = AR;
        end
      end

      AR: begin
        if (m_axil_arready) begin
          state_d = R;
`ifdef SVC_AXIL_ARBITER_RD_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end

      R: begin
        for (int k = 0; k < NUM_M; k++) begin
          if (IW'(k) == gnt_q) begin
            s_axil_rvalid[k]          = m_axil_rvalid;
            s_axil_rdata[k*DW +: DW]  = m_axil_rdata;
            s_axil_rresp[k*2 +: 2]    = m_axil_rresp;
          end
        end
        m_axil_rready = gnt_rready;
        if (m_axil_rvalid && gnt_rready) begin
          rr_ptr_d = next_ptr;
          active_d = 1'b0;
          state_d  = IDLE;
        end
`ifdef SVC_AXIL_ARBITER_RD_TIMEOUT_EN
        // A response present in the firing cycle wins over the timeout.
        else if (!m_axil_rvalid && cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          state_d = TMO;
        end else if (cnt_q != CW'(TIMEOUT_CYCLES - 1)) begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end

`ifdef SVC_AXIL_ARBITER_RD_TIMEOUT_EN
      TMO: begin
        // Locally generated error; the late downstream response is held off
        // (rready low) until DRAIN.
        for (int k = 0; k < NUM_M; k++) begin
          if (IW'(k) == gnt_q) begin
            s_axil_rvalid[k]          = 1'b1;
            s_axil_rdata[k*DW +: DW]  = TO_DATA;
            s_axil_rresp[k*2 +: 2]    = 2'b10;
          end
        end
        if (gnt_rready) begin
          rr_ptr_d = next_ptr;
          state_d  = DRAIN;
        end
      end

      DRAIN: begin
        m_axil_rready = 1'b1;
        if (m_axil_rvalid) begin
          active_d = 1'b0;
          state_d  = IDLE;
        end
      end
`endif

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_svc_axil_arbiter_rd.sv
// tb/tb_svc_axil_arbiter_rd.sv - self-checking bench for svc_axil_arbiter_rd
module tb_svc_axil_arbiter_rd;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NM = 3;
  localparam int TO = 8;
  localparam int NV = 11;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [NM-1:0]    s_arvalid, s_arready, s_rvalid, s_rready;
  logic [NM*AW-1:0] s_araddr;
  logic [NM*DW-1:0] s_rdata;
  logic [NM*2-1:0]  s_rresp;
  logic             m_arvalid, m_arready, m_rvalid, m_rready;
  logic [AW-1:0]    m_araddr;
  logic [DW-1:0]    m_rdata;
  logic [1:0]       m_rresp;

  svc_axil_arbiter_rd #(
    .AXIL_ADDR_WIDTH(AW), .AXIL_DATA_WIDTH(DW), .NUM_M(NM), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axil_arvalid(s_arvalid), .s_axil_araddr(s_araddr), .s_axil_arready(s_arready),
    .s_axil_rvalid(s_rvalid), .s_axil_rdata(s_rdata), .s_axil_rresp(s_rresp),
    .s_axil_rready(s_rready),
    .m_axil_arvalid(m_arvalid), .m_axil_araddr(m_araddr), .m_axil_arready(m_arready),
    .m_axil_rvalid(m_rvalid), .m_axil_rdata(m_rdata), .m_axil_rresp(m_rresp),
    .m_axil_rready(m_rready)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [NM-1:0] req;
    int            gnt;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [1:0]    resp;
    int            ar_stall;
    int            r_stall;
  } vec_t;

  typedef struct {
    int            mgr;
    logic [DW-1:0] data;
    logic [1:0]    resp;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[NV];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pops the scoreboard when a manager-side R handshake is visible.
  task automatic sb_check();
    exp_t e;
    int   hit;
    hit = -1;
    for (int k = 0; k < NM; k++) if (s_rvalid[k] && s_rready[k]) hit = k;
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL sb_empty actual=response required=none");
    end else begin
      e = sb.pop_front();
      chk("sb_mgr", 64'(hit), 64'(e.mgr));
      if (hit >= 0) begin
        chk("sb_data", s_rdata[hit*DW +: DW], e.data);
        chk("sb_resp", s_rresp[hit*2 +: 2], e.resp);
      end
    end
  endtask

  // One full transaction; entered and left at a sample point in IDLE.
  task automatic serve(input vec_t v);
    logic [NM-1:0] gmask;
    exp_t e;
    gmask = '0;
    gmask[v.gnt] = 1'b1;
    s_arvalid = v.req;
    for (int k = 0; k < NM; k++) s_araddr[k*AW +: AW] = (k == v.gnt) ? v.addr : ~v.addr;
    #1;
    chk("idle_arvalid", m_arvalid, 0);
    chk("arready_gnt", s_arready, gmask);
    e.mgr = v.gnt; e.data = v.data; e.resp = v.resp;
    sb.push_back(e);
    step();
    s_arvalid[v.gnt] = 1'b0;
    #1;
    chk("ar_latency", m_arvalid, 1);
    chk("ar_addr", m_araddr, v.addr);
    chk("arready_busy", s_arready, 0);
    m_rvalid = 1'b1;
    #1;
    chk("stray_rvalid", s_rvalid, 0);
    chk("rready_in_ar", m_rready, 0);
    m_rvalid = 1'b0;
    for (int i = 0; i < v.ar_stall; i++) begin
      step();
      chk("ar_hold_valid", m_arvalid, 1);
      chk("ar_hold_addr", m_araddr, v.addr);
    end
    m_arready = 1'b1;
    step();
    m_arready = 1'b0;
    #1;
    chk("ar_done", m_arvalid, 0);
    m_rvalid = 1'b1; m_rdata = v.data; m_rresp = v.resp;
    s_rready = ~gmask;
    #1;
    for (int i = 0; i < v.r_stall; i++) begin
      chk("r_stall_rready", m_rready, 0);
      chk("r_stall_route", s_rvalid, gmask);
      step();
    end
    for (int k = 0; k < NM; k++) begin
      chk("r_data_route", s_rdata[k*DW +: DW], (k == v.gnt) ? v.data : '0);
      chk("r_resp_route", s_rresp[k*2 +: 2], (k == v.gnt) ? v.resp : 2'b00);
    end
    s_rready[v.gnt] = 1'b1;
    #1;
    chk("r_valid_only_gnt", s_rvalid, gmask);
    chk("rready_pass", m_rready, 1);
    sb_check();
    step();
    m_rvalid = 1'b0;
    s_rready = '0;
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    s_arvalid = '0; s_araddr = '0; s_rready = '0;
    m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = '0; m_rresp = '0;

    //           req     gnt addr          data          resp  ars rs
    tbl[0]  = '{3'b111, 0, 32'h0000_0100, 32'h0000_0A00, 2'b00, 0, 0};
    tbl[1]  = '{3'b110, 1, 32'h0000_0110, 32'h0000_0A01, 2'b00, 0, 0};
    tbl[2]  = '{3'b100, 2, 32'h0000_0120, 32'h0000_0A02, 2'b01, 0, 0};
    tbl[3]  = '{3'b010, 1, 32'h0000_1000, 32'h1234_5678, 2'b00, 0, 0};
    tbl[4]  = '{3'b111, 2, 32'h0000_0200, 32'h0000_0B02, 2'b00, 0, 0};
    tbl[5]  = '{3'b011, 0, 32'h0000_0210, 32'h0000_0B00, 2'b00, 0, 0};
    tbl[6]  = '{3'b010, 1, 32'h0000_0220, 32'h0000_0B01, 2'b11, 0, 0};
    tbl[7]  = '{3'b001, 0, 32'h0000_3000, 32'hA5A5_5A5A, 2'b00, 5, 4};
    tbl[8]  = '{3'b101, 2, 32'h0000_4000, 32'hFFFF_FFFF, 2'b10, 0, 0};
    tbl[9]  = '{3'b110, 1, 32'h0000_5000, 32'h0BAD_F00D, 2'b01, 1, 2};
    tbl[10] = '{3'b001, 0, 32'h0000_6000, 32'hC0DE_0001, 2'b00, 0, 0};

    step(); step();
    chk("rst_arvalid", m_arvalid, 0);
    chk("rst_araddr", m_araddr, 0);
    chk("rst_arready", s_arready, 0);
    chk("rst_rvalid", s_rvalid, 0);
    rst_n = 1'b1;
    step();

    // Reset asserted mid-AR, away from any clock edge.
    s_arvalid = 3'b100;
    s_araddr[2*AW +: AW] = 32'h0000_ABCD;
    step();
    chk("pre_rst_arvalid", m_arvalid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_arvalid", m_arvalid, 0);
    chk("async_rst_arready", s_arready, 0);
    chk("async_rst_araddr", m_araddr, 0);
    s_arvalid = '0;
    step();
    rst_n = 1'b1;
    step();
    m_rvalid = 1'b1;
    #1;
    chk("post_rst_no_resp", s_rvalid, 0);
    chk("post_rst_rready", m_rready, 0);
    m_rvalid = 1'b0;
    s_arvalid = 3'b001;
    #1;
    chk("post_rst_idle", s_arready, 3'b001);
    // Requester withdraws before the edge: never granted.
    s_arvalid = '0;
    step();
    chk("withdrawn_no_grant", m_arvalid, 0);

    for (int i = 0; i < NV; i++) serve(tbl[i]);

`ifdef SVC_AXIL_ARBITER_RD_TIMEOUT_EN
    // rr_ptr is 1 here; manager 1 times out.
    s_arvalid = 3'b010;
    s_araddr[1*AW +: AW] = 32'h0000_2000;
    #1;
    chk("to_arready", s_arready, 3'b010);
    step();
    s_arvalid = '0;
    m_arready = 1'b1;
    step();
    m_arready = 1'b0;
    for (int i = 0; i < TO; i++) begin
      #1;
      chk("to_wait", s_rvalid, 0);
      step();
    end
    #1;
    chk("to_rvalid", s_rvalid, 3'b010);
    chk("to_rdata", s_rdata[1*DW +: DW], 32'hDEAD_BEEF);
    chk("to_rresp", s_rresp[1*2 +: 2], 2'b10);
    chk("to_rready_held", m_rready, 0);
    s_rready = 3'b010;
    step();
    s_rready = '0;
    #1;
    chk("drain_rready", m_rready, 1);
    m_rvalid = 1'b1; m_rdata = 32'h5555_5555;
    #1;
    chk("drain_silent", s_rvalid, 0);
    step();
    m_rvalid = 1'b0;
    s_arvalid = 3'b001;
    #1;
    chk("after_drain_grant", s_arready, 3'b001);
    s_arvalid = '0;
    step();
`endif

    chk("sb_drained", 64'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
